// File: rtl/multicycle_control_fsm.sv
// Multi-cycle CPU sequencing controller: steps each instruction through
// IF/ID/EXE/MEM/WB and decodes datapath enables from state, opcode and ALU flags.
module multicycle_control_fsm #(
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            sign,
    output logic            IRWre,
    output logic            PCWre,
    output logic [1:0]      PCSrc,
    output logic            RegWre,
    output logic            mRD,
    output logic            mWR,
    output logic [2:0]      state,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    localparam logic [OP_W-1:0] OP_ALU_MAX = OP_W'(6'b010111);
    localparam logic [OP_W-1:0] OP_BEQ     = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OP_BNE     = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OP_BLTZ    = OP_W'(6'b110010);
    localparam logic [OP_W-1:0] OP_J       = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OP_JR      = OP_W'(6'b111001);
    localparam logic [OP_W-1:0] OP_JAL     = OP_W'(6'b111010);
    localparam logic [OP_W-1:0] OP_SW      = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] OP_LW      = OP_W'(6'b100111);

    state_t state_q, state_d;

    logic is_alu, is_beq, is_bne, is_bltz, is_branch;
    logic is_j, is_jr, is_jal, is_sw, is_lw, is_mem, is_halt;
    logic taken;
    logic irw, pcw, rw, rd, wr;
    logic [1:0] pcs;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    always_comb begin
        is_halt   = (opcode == HALT_OP);
        is_alu    = (opcode <= OP_ALU_MAX);
        is_beq    = (opcode == OP_BEQ);
        is_bne    = (opcode == OP_BNE);
        is_bltz   = (opcode == OP_BLTZ);
        is_branch = is_beq | is_bne | is_bltz;
        is_j      = (opcode == OP_J);
        is_jr     = (opcode == OP_JR);
        is_jal    = (opcode == OP_JAL);
        is_sw     = (opcode == OP_SW);
        is_lw     = (opcode == OP_LW);
        is_mem    = is_sw | is_lw;
        taken     = (is_beq & zero) | (is_bne & ~zero) | (is_bltz & sign);
    end

    always_comb begin
        state_d = state_q;
        irw     = 1'b0;
        pcw     = 1'b0;
        pcs     = 2'b00;
        rw      = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        case (state_q)
            S_IF: begin
                irw     = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_alu | is_branch | is_mem) begin
                    state_d = S_EXE;
                end else begin
                    // Jumps and NOPs retire here; jal links into $31 in the same cycle.
                    pcw     = 1'b1;
                    state_d = S_IF;
                    if (is_j | is_jal) pcs = 2'b10;
                    else if (is_jr)    pcs = 2'b11;
                    rw      = is_jal;
                end
            end
            S_EXE: begin
                if (is_branch) begin
                    pcw     = 1'b1;
                    pcs     = taken ? 2'b01 : 2'b00;
                    state_d = S_IF;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    wr      = 1'b1;
                    pcw     = 1'b1;
                    state_d = S_IF;
                end else begin
                    rd      = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rw      = 1'b1;
                pcw     = 1'b1;
                rd      = is_lw;
                state_d = S_IF;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Enables are forced low while Reset is held, even though state already reads IF.
    assign IRWre  = irw & ~Reset;
    assign PCWre  = pcw & ~Reset;
    assign PCSrc  = Reset ? 2'b00 : pcs;
    assign RegWre = rw & ~Reset;
    assign mRD    = rd & ~Reset;
    assign mWR    = wr & ~Reset;
    assign state  = state_q;
    assign halted = (state_q == S_HALT);

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle CPU; the other end of the instruction-register interface.
- Generates IRWre, which strobes the fetched word into the instruction register.
- Steps each instruction through IF/ID/EXE/MEM/WB and issues the per-state write enables and PC-source select to the datapath.
- Decodes the latched opcode plus ALU flags; owns the halt state.

Parameters:
- OP_W, 6, opcode width (Instruction[31:26]).
- HALT_OP, 6'b111111, opcode that enters the HALT state.

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high; forces state to IF.
- opcode  input  OP_W  Instruction[31:26] from the instruction register.
- zero  input  1  ALU result == 0.
- sign  input  1  ALU result MSB.
- IRWre  output  1  instruction register load enable.
- PCWre  output  1  PC load enable.
- PCSrc  output  2  00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs (jr).
- RegWre  output  1  register-file write enable.
- mRD  output  1  data-memory read.
- mWR  output  1  data-memory write.
- state  output  3  current state, for debug.
- halted  output  1  high while in HALT.

Behaviour:
- Opcode classes:
  - ALU: 000000–010111. Covers R-type and immediate forms.
  - Branch: beq 110000, bne 110001, bltz 110010.
  - Jump: j 111000, jal 111010, jr 111001.
  - Memory: sw 100110, lw 100111.
  - Halt: HALT_OP.
  - Any other opcode is a NOP.
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111.
- Only state is registered (asynchronous Reset sets IF). Outputs decode combinationally from state, opcode and flags.
- While Reset=1, all enables are 0 and PCSrc=00.
- Outputs are 0 wherever not listed below.
- IF:
  - IRWre=1.
  - Next state: ID.
- ID:
  - j: PCWre=1, PCSrc=10; next state IF.
  - jal: PCWre=1, PCSrc=10, RegWre=1 (writes $31); next state IF.
  - jr: PCWre=1, PCSrc=11; next state IF.
  - NOP: PCWre=1, PCSrc=00; next state IF.
  - HALT_OP: next state HALT; PCWre=0.
  - All other opcodes: next state EXE.
- EXE:
  - Branch: PCWre=1 and next state IF.
  - Branch taken condition: beq taken iff zero=1; bne iff zero=0; bltz iff sign=1. Taken gives PCSrc=01, otherwise 00.
  - sw/lw: next state MEM.
  - ALU: next state WB.
- MEM:
  - sw: mWR=1, PCWre=1, PCSrc=00; next state IF.
  - lw: mRD=1; next state WB.
- WB:
  - RegWre=1, PCWre=1, PCSrc=00.
  - lw keeps mRD=1 in WB.
  - Next state: IF.
- HALT:
  - Absorbing until Reset; halted=1.
  - IRWre, PCWre, RegWre and mWR all stay 0.
- Per-instruction cycle counts:
  - j, jal, jr, NOP: 2.
  - Branch: 3.
  - ALU and sw: 4.
  - lw: 5.
- Invariants:
  - Exactly one IRWre pulse per instruction.
  - PCWre is high in exactly one cycle per instruction, and never in the same cycle as IRWre.
- Reset mid-instruction: state becomes IF immediately (asynchronous); the partial instruction's pending writes are dropped.
- Once Reset deasserts, IRWre=1 in the first cycle.
- Opcode is sampled every cycle. The instruction register holds the opcode stable from ID onward, because IRWre is only high in IF.

Test Plan:
- Reset asserted mid-EXE, released → state=000 asynchronously, all enables 0; first post-reset cycle IRWre=1.
- Opcode 000000 (add) → state sequence 000,001,010,100,000. IRWre in cycle 0 only; RegWre=1 and PCWre=1 only in WB; PCSrc=00.
- lw 100111 → states 000,001,010,011,100. mRD=1 in MEM and WB; RegWre only in WB; 5 cycles total.
- sw 100110 → 4 cycles; mWR=1 and PCWre=1 only in MEM; RegWre never asserted.
- beq with zero=1 → PCSrc=01 in EXE. beq with zero=0 → PCSrc=00. bltz with sign=1 → PCSrc=01. All three take 3 cycles.
- jal 111010 → 2 cycles; in ID, PCWre=1, PCSrc=10, RegWre=1. Then 111111 → HALT after ID; halted=1, no IRWre for 20 cycles, until Reset.
